xbar_row_sequencer: RTL and testbench

Command-level controller that sequences the crossbar post-processing stage row by row. It accepts one COMPUTE, WRITE or READ command at a time from the layer scheduler and drives the forward bus (control, row, id, address, data, threshold) of the crossbar/after-module pipeline. For COMPUTE it steps rows 0..last_row, holding each row for the bit-serial result capture window, then drains. It reports completion with a one-cycle done pulse.

---
 rtl/xbar_row_sequencer_pkg.sv | 27 ++
 rtl/xbar_row_sequencer_row_counter.sv | 51 +++++
 rtl/xbar_row_sequencer.sv | 158 +++++++++++++++
 tb/tb_xbar_row_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_row_sequencer_pkg.sv
//------------------------------------------------------------------------------
// xbar_row_sequencer_pkg : bus opcodes, FSM states and widths for the sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package xbar_row_sequencer_pkg;

  localparam int ROW_W  = 4;
  localparam int DATA_W = 64;

  // Forward-bus opcodes, shared with the after-module
  localparam logic [1:0] OP_SLEEP   = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_COMPUTE = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_ACCESS  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/xbar_row_sequencer_row_counter.sv
//------------------------------------------------------------------------------
// xbar_row_counter : phase/row stepper for COMPUTE jobs with terminal flag
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xbar_row_counter
  import xbar_row_sequencer_pkg::*;
#(
  parameter int ROW_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             run,
  input  logic [ROW_W-1:0] last_row,
  output logic [ROW_W-1:0] row,
  output logic             job_end
);

  localparam int PH_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;

  logic [PH_W-1:0]  r_phase;
  logic [ROW_W-1:0] r_row;
  logic             w_phase_wrap;

  assign w_phase_wrap = (r_phase == PH_W'(ROW_CYCLES - 1));
  assign job_end      = run && w_phase_wrap && (r_row == last_row);
  assign row          = r_row;

  // Row stops on last_row, so it can never wrap past the top index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_row   <= '0;
    end else if (clr) begin
      r_phase <= '0;
      r_row   <= '0;
    end else if (run) begin
      if (w_phase_wrap) begin
        r_phase <= '0;
        if (r_row != last_row) r_row <= r_row + 1'b1;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/xbar_row_sequencer.sv
//------------------------------------------------------------------------------
// xbar_row_sequencer : command FSM driving the crossbar forward bus row by row
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xbar_row_sequencer
  import xbar_row_sequencer_pkg::*;
#(
  parameter int ROW_CYCLES    = 3,
  parameter int DRAIN_CYCLES  = 2,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_id,
  input  logic [11:0]       cmd_address,
  input  logic [1:0]        cmd_xbar_address,
  input  logic [DATA_W-1:0] cmd_data_c,
  input  logic              cmd_data_w,
  input  logic [3:0]        cmd_threshold,
  input  logic [ROW_W-1:0]  cmd_last_row,
  output logic [1:0]        fwd_control,
  output logic [ROW_W-1:0]  fwd_row,
  output logic [7:0]        fwd_id,
  output logic [11:0]       fwd_address,
  output logic [1:0]        fwd_xbar_address,
  output logic [DATA_W-1:0] fwd_data_c,
  output logic              fwd_data_w,
  output logic [3:0]        fwd_sigmoid_threshold,
  output logic              busy,
  output logic              done,
  output logic [7:0]        done_id
);

  localparam int CNT_W = 8;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [ROW_W-1:0] r_last_row;
  logic             r_done;
  logic [7:0]       r_done_id;
  logic             w_accept, w_done_set, w_job_end;

  assign w_accept = cmd_valid && (r_state == ST_IDLE) && !flush;

  xbar_row_counter #(
    .ROW_CYCLES (ROW_CYCLES)
  ) u_row_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush || w_accept),
    .run      (r_state == ST_COMPUTE),
    .last_row (r_last_row),
    .row      (fwd_row),
    .job_end  (w_job_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_done_set   = 1'b0;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    fwd_control  = OP_SLEEP;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept) begin
          if (cmd_op == OP_COMPUTE)                           w_state_next = ST_COMPUTE;
          else if (cmd_op == OP_WRITE || cmd_op == OP_READ)   w_state_next = ST_ACCESS;
        end
      end
      ST_COMPUTE: begin
        fwd_control = OP_COMPUTE;
        if (w_job_end) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
          w_state_next = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end
      ST_ACCESS: begin
        fwd_control = r_op;
        if (r_cnt == CNT_W'(ACCESS_CYCLES - 1)) begin
          w_state_next = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Abort wins over every transition, including a same-cycle accept
    if (flush) begin
      w_state_next = ST_IDLE;
      w_done_set   = 1'b0;
    end
  end

  // Hold counter restarts on every state change so each state counts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (flush || (w_state_next != r_state)) begin
      r_cnt <= '0;
    end else if (r_state == ST_DRAIN || r_state == ST_ACCESS) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op                  <= OP_SLEEP;
      r_last_row            <= '0;
      fwd_id                <= '0;
      fwd_address           <= '0;
      fwd_xbar_address      <= '0;
      fwd_data_c            <= '0;
      fwd_data_w            <= 1'b0;
      fwd_sigmoid_threshold <= '0;
    end else if (w_accept) begin
      r_op                  <= cmd_op;
      r_last_row            <= cmd_last_row;
      fwd_id                <= cmd_id;
      fwd_address           <= cmd_address;
      fwd_xbar_address      <= cmd_xbar_address;
      fwd_data_c            <= cmd_data_c;
      fwd_data_w            <= cmd_data_w;
      fwd_sigmoid_threshold <= cmd_threshold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_done_id <= '0;
    end else begin
      r_done <= w_done_set;
      if (w_done_set) r_done_id <= fwd_id;
    end
  end

  assign done    = r_done;
  assign done_id = r_done_id;

endmodule

`default_nettype wire

// File: tb/tb_xbar_row_sequencer.sv
//------------------------------------------------------------------------------
// tb_xbar_row_sequencer : directed self-checking bench for xbar_row_sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_xbar_row_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_id = 8'h00;
  logic [11:0] cmd_address = 12'h000;
  logic [1:0]  cmd_xbar_address = 2'b00;
  logic [63:0] cmd_data_c = 64'h0;
  logic        cmd_data_w = 1'b0;
  logic [3:0]  cmd_threshold = 4'h0;
  logic [3:0]  cmd_last_row = 4'h0;
  logic [1:0]  fwd_control;
  logic [3:0]  fwd_row;
  logic [7:0]  fwd_id;
  logic [11:0] fwd_address;
  logic [1:0]  fwd_xbar_address;
  logic [63:0] fwd_data_c;
  logic        fwd_data_w;
  logic [3:0]  fwd_sigmoid_threshold;
  logic        busy;
  logic        done;
  logic [7:0]  done_id;

  int total = 0;
  int bad   = 0;

  xbar_row_sequencer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .flush                 (flush),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_op                (cmd_op),
    .cmd_id                (cmd_id),
    .cmd_address           (cmd_address),
    .cmd_xbar_address      (cmd_xbar_address),
    .cmd_data_c            (cmd_data_c),
    .cmd_data_w            (cmd_data_w),
    .cmd_threshold         (cmd_threshold),
    .cmd_last_row          (cmd_last_row),
    .fwd_control           (fwd_control),
    .fwd_row               (fwd_row),
    .fwd_id                (fwd_id),
    .fwd_address           (fwd_address),
    .fwd_xbar_address      (fwd_xbar_address),
    .fwd_data_c            (fwd_data_c),
    .fwd_data_w            (fwd_data_w),
    .fwd_sigmoid_threshold (fwd_sigmoid_threshold),
    .busy                  (busy),
    .done                  (done),
    .done_id               (done_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one command for one edge; returns in the first cycle after accept
  task automatic issue(input logic [1:0] op, input logic [7:0] id,
                       input logic [3:0] last, input logic [1:0] xa);
    cmd_valid        = 1'b1;
    cmd_op           = op;
    cmd_id           = id;
    cmd_last_row     = last;
    cmd_xbar_address = xa;
    cmd_address      = {4'h3, id};
    cmd_data_c       = {8{id}};
    cmd_data_w       = id[0];
    cmd_threshold    = 4'b1011;
    tick();
    cmd_valid = 1'b0;
  endtask

  // (L+1)*3 COMPUTE cycles, 2 SLEEP drain cycles, done in the next cycle
  task automatic check_compute(input logic [7:0] id, input int last);
    int n_comp;
    n_comp = (last + 1) * 3;
    for (int c = 1; c <= n_comp + 3; c++) begin
      if (c <= n_comp) begin
        chk("cmp_ctrl", 64'(fwd_control), 64'(2'b10));
        chk("cmp_row", 64'(fwd_row), 64'((c - 1) / 3));
        chk("cmp_ready", 64'(cmd_ready), 64'd0);
        chk("cmp_done", 64'(done), 64'd0);
      end else if (c <= n_comp + 2) begin
        chk("drain_ctrl", 64'(fwd_control), 64'd0);
        chk("drain_row", 64'(fwd_row), 64'(last));
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_done", 64'(done), 64'd0);
      end else begin
        chk("cmp_done_pulse", 64'(done), 64'd1);
        chk("cmp_done_id", 64'(done_id), 64'(id));
        chk("cmp_idle_busy", 64'(busy), 64'd0);
        chk("cmp_idle_ready", 64'(cmd_ready), 64'd1);
      end
      tick();
    end
    chk("cmp_done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_ctrl", 64'(fwd_control), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_done_id", 64'(done_id), 64'd0);
    chk("rst_row", 64'(fwd_row), 64'd0);
    chk("rst_id", 64'(fwd_id), 64'd0);
    chk("rst_data_c", fwd_data_c, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(cmd_ready), 64'd1);

    // Single-row COMPUTE
    issue(2'b10, 8'h5A, 4'd0, 2'b10);
    check_compute(8'h5A, 0);

    // Full 16-row COMPUTE with field checks
    issue(2'b10, 8'hC3, 4'd15, 2'b11);
    chk("f_id", 64'(fwd_id), 64'hC3);
    chk("f_addr", 64'(fwd_address), 64'h3C3);
    chk("f_xbar", 64'(fwd_xbar_address), 64'h3);
    chk("f_data_c", fwd_data_c, 64'hC3C3C3C3C3C3C3C3);
    chk("f_data_w", 64'(fwd_data_w), 64'd1);
    chk("f_thr", 64'(fwd_sigmoid_threshold), 64'hB);
    check_compute(8'hC3, 15);
    chk("f_id_kept", 64'(fwd_id), 64'hC3);
    chk("f_data_kept", fwd_data_c, 64'hC3C3C3C3C3C3C3C3);

    // READ then WRITE accepted in the READ done cycle
    issue(2'b11, 8'h11, 4'd0, 2'b10);
    for (int c = 1; c <= 2; c++) begin
      chk("rd_ctrl", 64'(fwd_control), 64'h3);
      chk("rd_xbar", 64'(fwd_xbar_address), 64'h2);
      chk("rd_busy", 64'(busy), 64'd1);
      chk("rd_done", 64'(done), 64'd0);
      tick();
    end
    chk("rd_done_pulse", 64'(done), 64'd1);
    chk("rd_done_id", 64'(done_id), 64'h11);
    chk("rd_done_ready", 64'(cmd_ready), 64'd1);
    chk("rd_done_ctrl", 64'(fwd_control), 64'd0);
    issue(2'b01, 8'h22, 4'd0, 2'b11);
    for (int c = 1; c <= 2; c++) begin
      chk("wr_ctrl", 64'(fwd_control), 64'h1);
      chk("wr_id", 64'(fwd_id), 64'h22);
      chk("wr_done", 64'(done), 64'd0);
      chk("wr_ready", 64'(cmd_ready), 64'd0);
      tick();
    end
    chk("wr_done_pulse", 64'(done), 64'd1);
    chk("wr_done_id", 64'(done_id), 64'h22);
    tick();
    chk("wr_done_clear", 64'(done), 64'd0);

    // Flush at row 4 phase 1 (cycle 14 after accept)
    issue(2'b10, 8'h44, 4'd15, 2'b10);
    for (int c = 1; c < 14; c++) tick();
    chk("fl_row_before", 64'(fwd_row), 64'd4);
    chk("fl_ctrl_before", 64'(fwd_control), 64'h2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_ctrl", 64'(fwd_control), 64'd0);
    chk("fl_busy", 64'(busy), 64'd0);
    chk("fl_row", 64'(fwd_row), 64'd0);
    chk("fl_done", 64'(done), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fl_no_done", 64'(done), 64'd0);
    end

    // Flush together with cmd_valid in IDLE blocks the accept
    flush = 1'b1;
    issue(2'b10, 8'h77, 4'd2, 2'b10);
    flush = 1'b0;
    chk("flv_busy", 64'(busy), 64'd0);
    chk("flv_ctrl", 64'(fwd_control), 64'd0);
    chk("flv_id", 64'(fwd_id), 64'h44);
    tick();
    chk("flv_busy2", 64'(busy), 64'd0);

    // SLEEP command is consumed with no activity
    issue(2'b00, 8'h99, 4'd0, 2'b10);
    chk("sl_busy", 64'(busy), 64'd0);
    chk("sl_ctrl", 64'(fwd_control), 64'd0);
    chk("sl_done", 64'(done), 64'd0);
    chk("sl_ready", 64'(cmd_ready), 64'd1);
    tick();
    chk("sl_done2", 64'(done), 64'd0);
    chk("sl_busy2", 64'(busy), 64'd0);

    // Asynchronous reset at row 7 (cycle 22 after accept)
    issue(2'b10, 8'h66, 4'd15, 2'b11);
    for (int c = 1; c < 22; c++) tick();
    chk("ar_row_before", 64'(fwd_row), 64'd7);
    rst_n = 1'b0;
    #1;
    chk("ar_ctrl", 64'(fwd_control), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    chk("ar_row", 64'(fwd_row), 64'd0);
    chk("ar_id", 64'(fwd_id), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("ar_ready", 64'(cmd_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("ar_no_done", 64'(done), 64'd0);
      chk("ar_idle_ctrl", 64'(fwd_control), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
